// File: rtl/iob_mem_responder_pkg.sv
// Shared defaults, legal-range check and byte-merge helper for the IOb memory responder.
// This package also holds the legal-range check on the read latency and response depth.
package iob_mem_responder_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int MEM_ADDR_W_DEF = 10;
    localparam int RD_LAT_DEF     = 1;
    localparam int RESP_DEPTH_DEF = 2;

    function automatic bit cfg_ok(input int addr_w, input int data_w, input int mem_addr_w,
                                  input int rd_lat, input int resp_depth);
        return (data_w == 32) && (rd_lat >= 1) && (rd_lat <= 4) &&
               (resp_depth >= rd_lat) && (addr_w > mem_addr_w + 2);
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/iob_mem_responder_if.sv
// IOb request/response bus bundle; master is the CPU side, slave the memory responder.
interface iob_mem_responder_if
    import iob_mem_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic                  iob_valid;
    logic [ADDR_W-1:0]     iob_addr;
    logic [DATA_W-1:0]     iob_wdata;
    logic [DATA_W/8-1:0]   iob_wstrb;
    logic                  iob_rready;
    logic                  iob_ready;
    logic [DATA_W-1:0]     iob_rdata;
    logic                  iob_rvalid;

    modport master (
        output iob_valid, iob_addr, iob_wdata, iob_wstrb, iob_rready,
        input  iob_ready, iob_rdata, iob_rvalid
    );

    modport slave (
        input  iob_valid, iob_addr, iob_wdata, iob_wstrb, iob_rready,
        output iob_ready, iob_rdata, iob_rvalid
    );

endinterface

// File: rtl/iob_resp_fifo.sv
// Synchronous response FIFO; head comes straight from the storage registers (first-word-fall-through).
module iob_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  storage [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign head    = storage[rd_ptr];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_i) begin
        if (arst_n_i) assert (!(push && full && !pop));
    end

endmodule

// File: rtl/iob_mem_responder.sv
// IOb responder around a byte-writable register-array memory with pipelined, credit-limited reads.
module iob_mem_responder
    import iob_mem_responder_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_ADDR_W = MEM_ADDR_W_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    iob_mem_responder_if.slave bus,
    output logic              err_o
);

    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic [DATA_W-1:0]     mem [2**MEM_ADDR_W];
    logic [MEM_ADDR_W-1:0] word_idx;
    logic [1:0]            unused_addr_lsb;
    logic                  oor, acc, rd_acc, wr_acc;
    logic [DATA_W-1:0]     rd_word;
    logic                  push, pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0]     push_data, fifo_head;
    logic [CW-1:0]         cnt_q, cnt_nxt;
    logic                  ready_q, err_q;

    assign word_idx        = bus.iob_addr[MEM_ADDR_W+1:2];
    assign unused_addr_lsb = bus.iob_addr[1:0];
    assign oor             = |bus.iob_addr[ADDR_W-1:MEM_ADDR_W+2];
    assign acc             = bus.iob_valid & ready_q;
    assign rd_acc          = acc & (bus.iob_wstrb == '0);
    assign wr_acc          = acc & (|bus.iob_wstrb);
    // Writes land at the accepting edge, so a read accepted next cycle already sees them.
    assign rd_word         = oor ? '0 : mem[word_idx];

    always_ff @(posedge clk_i) begin
        if (wr_acc && !oor) mem[word_idx] <= byte_merge(mem[word_idx], bus.iob_wdata, bus.iob_wstrb);
    end

    // Stage 0 is the memory read itself; extra register stages are added for RD_LAT > 1.
    if (RD_LAT == 1) begin : g_lat1
        assign push      = rd_acc;
        assign push_data = rd_word;
    end else begin : g_pipe
        logic [RD_LAT-2:0]             vld_p;
        logic [RD_LAT-2:0][DATA_W-1:0] data_p;

        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                vld_p <= '0;
            end else begin
                vld_p[0] <= rd_acc;
                for (int k = 1; k < RD_LAT - 1; k++) vld_p[k] <= vld_p[k-1];
            end
        end

        always_ff @(posedge clk_i) begin
            data_p[0] <= rd_word;
            for (int k = 1; k < RD_LAT - 1; k++) data_p[k] <= data_p[k-1];
        end

        assign push      = vld_p[RD_LAT-2];
        assign push_data = data_p[RD_LAT-2];
    end

    iob_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .W     (DATA_W)
    ) u_resp_fifo (
        .clk_i     (clk_i),
        .arst_n_i  (arst_n_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pop            = ~fifo_empty & bus.iob_rready;
    assign bus.iob_rvalid = ~fifo_empty;
    assign bus.iob_rdata  = fifo_empty ? '0 : fifo_head;
    assign bus.iob_ready  = ready_q;
    assign err_o          = err_q;

    // Credit counts reads from acceptance until their response is popped.
    assign cnt_nxt = cnt_q + CW'(rd_acc) - CW'(pop);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_nxt;
            ready_q <= (cnt_nxt < CW'(RESP_DEPTH));
            err_q   <= err_q | (acc & oor);
        end
    end

    always_ff @(posedge clk_i) begin
        assert (cfg_ok(ADDR_W, DATA_W, MEM_ADDR_W, RD_LAT, RESP_DEPTH));
    end

endmodule

// File: tb/tb_iob_mem_responder.sv
// Directed bench: DUT a uses RD_LAT=1/RESP_DEPTH=2, DUT b uses RD_LAT=2/RESP_DEPTH=3.
module tb_iob_mem_responder;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic err_a, err_b;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    iob_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) if_a ();
    iob_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) if_b ();

    iob_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .RD_LAT(1), .RESP_DEPTH(2)) u_dut_a (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .bus      (if_a),
        .err_o    (err_a)
    );

    iob_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .RD_LAT(2), .RESP_DEPTH(3)) u_dut_b (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .bus      (if_b),
        .err_o    (err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if_a.iob_valid = 1'b1; if_a.iob_addr = addr; if_a.iob_wdata = data; if_a.iob_wstrb = strb;
        @(negedge clk);
        for (int i = 0; i < 8 && !if_a.iob_ready; i++) begin step; @(negedge clk); end
        chk("wr_a_accept", if_a.iob_ready, 1);
        step;
        if_a.iob_valid = 1'b0; if_a.iob_wstrb = '0;
    endtask

    task automatic wr_b(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if_b.iob_valid = 1'b1; if_b.iob_addr = addr; if_b.iob_wdata = data; if_b.iob_wstrb = strb;
        @(negedge clk);
        for (int i = 0; i < 8 && !if_b.iob_ready; i++) begin step; @(negedge clk); end
        chk("wr_b_accept", if_b.iob_ready, 1);
        step;
        if_b.iob_valid = 1'b0; if_b.iob_wstrb = '0;
    endtask

    task automatic rd_a_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        if_a.iob_valid = 1'b1; if_a.iob_addr = addr; if_a.iob_wstrb = '0;
        @(negedge clk);
        for (int i = 0; i < 8 && !if_a.iob_ready; i++) begin step; @(negedge clk); end
        chk({tag, "_acc"}, if_a.iob_ready, 1);
        step;
        if_a.iob_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid"}, if_a.iob_rvalid, 1);
        chk({tag, "_rdata"}, if_a.iob_rdata, exp);
        step;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nresp, first_rv, last_rv;
        if_a.iob_valid = 0; if_a.iob_addr = '0; if_a.iob_wdata = '0; if_a.iob_wstrb = '0; if_a.iob_rready = 0;
        if_b.iob_valid = 0; if_b.iob_addr = '0; if_b.iob_wdata = '0; if_b.iob_wstrb = '0; if_b.iob_rready = 0;

        // 1: reset
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t1_ready_in_reset_a", if_a.iob_ready, 0);
            chk("t1_ready_in_reset_b", if_b.iob_ready, 0);
        end
        step;
        arst_n = 1'b1;
        step;
        @(negedge clk);
        chk("t1_ready_a", if_a.iob_ready, 1);
        chk("t1_rvalid_a", if_a.iob_rvalid, 0);
        chk("t1_rdata_a", if_a.iob_rdata, 0);
        chk("t1_err_a", err_a, 0);
        chk("t1_ready_b", if_b.iob_ready, 1);
        step;

        // 2: write then read next cycle, RD_LAT=1
        if_a.iob_rready = 1'b1;
        wr_a(32'h10, 32'hDEADBEEF, 4'hF);
        if_a.iob_valid = 1'b1; if_a.iob_addr = 32'h10; if_a.iob_wstrb = '0;
        @(negedge clk);
        chk("t2_rd_ready", if_a.iob_ready, 1);
        chk("t2_rvalid_early", if_a.iob_rvalid, 0);
        step;
        if_a.iob_valid = 1'b0;
        @(negedge clk);
        chk("t2_rvalid", if_a.iob_rvalid, 1);
        chk("t2_rdata", if_a.iob_rdata, 32'hDEADBEEF);
        step;
        @(negedge clk);
        chk("t2_rvalid_after_pop", if_a.iob_rvalid, 0);
        step;

        // 3: byte strobes
        wr_a(32'h20, 32'h11223344, 4'hF);
        wr_a(32'h20, 32'hAABBCCDD, 4'h5);
        rd_a_check(32'h20, 32'h11BB33DD, "t3_strobe");

        // 4: backpressure with RESP_DEPTH=2
        wr_a(32'h0, 32'h000000A0, 4'hF);
        wr_a(32'h4, 32'h000000A4, 4'hF);
        wr_a(32'h8, 32'h000000A8, 4'hF);
        if_a.iob_rready = 1'b0;
        if_a.iob_valid = 1'b1; if_a.iob_addr = 32'h0; if_a.iob_wstrb = '0;
        @(negedge clk); chk("t4_acc0", if_a.iob_ready, 1);
        step; if_a.iob_addr = 32'h4;
        @(negedge clk); chk("t4_acc1", if_a.iob_ready, 1);
        chk("t4_head0", if_a.iob_rdata, 32'hA0);
        step; if_a.iob_addr = 32'h8;
        @(negedge clk); chk("t4_third_blocked", if_a.iob_ready, 0);
        chk("t4_rvalid_held", if_a.iob_rvalid, 1);
        step;
        @(negedge clk); chk("t4_still_blocked", if_a.iob_ready, 0);
        chk("t4_rdata_held", if_a.iob_rdata, 32'hA0);
        step; if_a.iob_rready = 1'b1;
        @(negedge clk); chk("t4_pop_no_same_cycle_ready", if_a.iob_ready, 0);
        chk("t4_resp0", if_a.iob_rdata, 32'hA0);
        step;
        @(negedge clk); chk("t4_third_accepted", if_a.iob_ready, 1);
        chk("t4_resp1", if_a.iob_rdata, 32'hA4);
        step; if_a.iob_valid = 1'b0;
        @(negedge clk); chk("t4_rvalid2", if_a.iob_rvalid, 1);
        chk("t4_resp2", if_a.iob_rdata, 32'hA8);
        step;
        @(negedge clk); chk("t4_drained", if_a.iob_rvalid, 0);
        step;

        // 5: streaming on DUT b, RD_LAT=2 RESP_DEPTH=3
        for (int i = 0; i < 16; i++) wr_b(32'(32'h40 + 4 * i), 32'(32'h5000 + i), 4'hF);
        if_b.iob_rready = 1'b1;
        nresp = 0; first_rv = -1; last_rv = -1;
        for (int c = 0; c < 24; c++) begin
            if_b.iob_valid = (c < 16); if_b.iob_addr = 32'(32'h40 + 4 * c); if_b.iob_wstrb = '0;
            @(negedge clk);
            if (c < 16) chk($sformatf("t5_acc%0d", c), if_b.iob_ready, 1);
            if (if_b.iob_rvalid) begin
                chk($sformatf("t5_rdata%0d", nresp), if_b.iob_rdata, 32'(32'h5000 + nresp));
                if (first_rv < 0) first_rv = c;
                last_rv = c;
                nresp++;
            end
            step;
        end
        if_b.iob_valid = 1'b0;
        chk("t5_count", nresp, 16);
        chk("t5_first_rvalid_cycle", first_rv, 2);
        chk("t5_last_rvalid_cycle", last_rv, 17);

        // 6: out-of-range access, sticky err, reset mid-stream
        chk("t6_err_pre", err_a, 0);
        if_a.iob_valid = 1'b1; if_a.iob_addr = 32'h1000; if_a.iob_wstrb = '0;
        @(negedge clk);
        chk("t6_oor_acc", if_a.iob_ready, 1);
        chk("t6_err_not_yet", err_a, 0);
        step; if_a.iob_valid = 1'b0;
        @(negedge clk);
        chk("t6_oor_rvalid", if_a.iob_rvalid, 1);
        chk("t6_oor_rdata", if_a.iob_rdata, 0);
        chk("t6_err_set", err_a, 1);
        step;
        wr_a(32'h1010, 32'hFFFFFFFF, 4'hF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); chk("t6_err_sticky", err_a, 1); step;
        end
        if_a.iob_rready = 1'b0;
        if_a.iob_valid = 1'b1; if_a.iob_addr = 32'h10; if_a.iob_wstrb = '0;
        step; step;
        if_a.iob_valid = 1'b0;
        @(negedge clk); chk("t6_queued_rvalid", if_a.iob_rvalid, 1);
        step;
        arst_n = 1'b0;
        #1;
        chk("t6_rvalid_in_reset", if_a.iob_rvalid, 0);
        chk("t6_ready_in_reset", if_a.iob_ready, 0);
        step; step;
        arst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); chk($sformatf("t6_no_rvalid%0d", c), if_a.iob_rvalid, 0); step;
        end
        chk("t6_ready_after", if_a.iob_ready, 1);
        chk("t6_err_cleared", err_a, 0);
        if_a.iob_rready = 1'b1;
        rd_a_check(32'h10, 32'hDEADBEEF, "t6_persist");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
